// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the data-memory request interface.
// Accepts one read or write at a time and answers with a single data_ok
// pulse a fixed LATENCY cycles after acceptance. Backed by a word array.
module data_sram_responder #(
  parameter int LATENCY        = 2,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o
);

  localparam int MEM_DEPTH = 1 << MEM_WORDS_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter is 4 bits wide, so LATENCY must stay within 1..15.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_sram_responder: LATENCY must be in 1..15");
  end

  logic [1:0]                state;
  logic [3:0]                cnt;
  logic                      lat_we;
  logic [MEM_WORDS_LOG2-1:0] lat_idx;
  logic [3:0]                lat_wstrb;
  logic [31:0]               lat_wdata;
  logic [MEM_WORDS_LOG2-1:0] req_idx;
  logic                      unused_addr;

  // Storage array; deliberately not reset, its contents survive rst.
  logic [31:0] mem [MEM_DEPTH];

  // Word index comes from the address bits above the byte offset; the
  // upper bits alias and the byte offset is ignored (lanes come from wstrb).
  assign req_idx     = addr_i[MEM_WORDS_LOG2+1:2];
  assign unused_addr = ^{addr_i[31:MEM_WORDS_LOG2+2], addr_i[1:0]};

  // Handshake outputs are pure state decodes, independent of req_i.
  assign addr_ok_o = (state == IDLE);
  assign data_ok_o = (state == RESP);

  // Control FSM: latch the request on acceptance, count down the latency,
  // and load read data on the edge that enters RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wstrb <= 4'd0;
      lat_wdata <= 32'd0;
      rdata_o   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            lat_we    <= we_i;
            lat_idx   <= req_idx;
            lat_wstrb <= wstrb_i;
            lat_wdata <= wdata_i;
            cnt       <= CNT_LOAD;
            if (LATENCY == 1) begin
              state   <= RESP;
              rdata_o <= we_i ? 32'd0 : mem[req_idx];
            end else begin
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= RESP;
            rdata_o <= lat_we ? 32'd0 : mem[lat_idx];
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write commit on the edge leaving RESP, lane by lane under the strobe.
  // A reset asserted at that edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && lat_we) begin
      for (int n = 0; n < 4; n++) begin
        if (lat_wstrb[n]) begin
          mem[lat_idx][8*n +: 8] <= lat_wdata[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed self-checking bench for data_sram_responder.
// Three instances: index 0 has LATENCY=2, index 1 LATENCY=1, index 2 LATENCY=4.
module tb_data_sram_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [31:0] addr  [3];
  logic [3:0]  wstrb [3];
  logic [31:0] wdata [3];
  logic [2:0]  addr_ok;
  logic [2:0]  data_ok;
  logic [31:0] rdata [3];

  int n_vec;
  int n_err;

  data_sram_responder #(.LATENCY(2), .MEM_WORDS_LOG2(10)) dut_l2 (
    .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wstrb_i(wstrb[0]), .wdata_i(wdata[0]), .addr_ok_o(addr_ok[0]),
    .data_ok_o(data_ok[0]), .rdata_o(rdata[0])
  );

  data_sram_responder #(.LATENCY(1), .MEM_WORDS_LOG2(10)) dut_l1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wstrb_i(wstrb[1]), .wdata_i(wdata[1]), .addr_ok_o(addr_ok[1]),
    .data_ok_o(data_ok[1]), .rdata_o(rdata[1])
  );

  data_sram_responder #(.LATENCY(4), .MEM_WORDS_LOG2(10)) dut_l4 (
    .clk(clk), .rst(rst), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
    .wstrb_i(wstrb[2]), .wdata_i(wdata[2]), .addr_ok_o(addr_ok[2]),
    .data_ok_o(data_ok[2]), .rdata_o(rdata[2])
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  // Drive one request on instance d and observe cycles 1..LATENCY+1 after
  // the acceptance edge (cycle 1 is the one right after that edge).
  task automatic run_txn(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd,
                         output logic [31:0] rd, output int ok_n,
                         output int ok_cyc, output logic busy_ok,
                         output logic back_ok, output logic [31:0] rd_hold);
    int l;
    l = lat_of(d);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wstrb[d] = s; wdata[d] = wd;
    @(posedge clk);
    #1 req[d] = 1'b0;
    ok_n = 0; ok_cyc = 0; busy_ok = 1'b1; back_ok = 1'b0;
    rd = 32'd0; rd_hold = 32'd0;
    for (int k = 1; k <= l + 1; k++) begin
      @(negedge clk);
      if (k <= l) begin
        if (addr_ok[d] !== 1'b0) busy_ok = 1'b0;
        if (data_ok[d] === 1'b1) begin
          ok_n++;
          ok_cyc = k;
          rd = rdata[d];
        end
      end else begin
        back_ok = (addr_ok[d] === 1'b1) && (data_ok[d] === 1'b0);
        rd_hold = rdata[d];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if (addr_ok[d] !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL reset_addr_ok[%0d] got %b want 1", d, addr_ok[d]);
      end
      n_vec++;
      if (data_ok[d] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL reset_data_ok[%0d] got %b want 0", d, data_ok[d]);
      end
      n_vec++;
      if (rdata[d] !== 32'd0) begin
        n_err++;
        $display("[TB] FAIL reset_rdata[%0d] got %h want 00000000", d, rdata[d]);
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd, rh;
    int ok_n, ok_cyc;
    logic busy_ok, back_ok;
    run_txn(0, 1'b1, 32'h10, 4'b1111, 32'h12345678, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (ok_n !== 1 || ok_cyc !== 2) begin
      n_err++;
      $display("[TB] FAIL wr_pulse got count=%0d cycle=%0d want count=1 cycle=2", ok_n, ok_cyc);
    end
    n_vec++;
    if (busy_ok !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL wr_addr_ok_low got addr_ok high while busy want low");
    end
    n_vec++;
    if (rd !== 32'd0) begin
      n_err++;
      $display("[TB] FAIL wr_rdata got %h want 00000000", rd);
    end
    n_vec++;
    if (back_ok !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL wr_ready_again got addr_ok/data_ok not 1/0 want 1/0");
    end
    run_txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (ok_n !== 1 || ok_cyc !== 2) begin
      n_err++;
      $display("[TB] FAIL rd_pulse got count=%0d cycle=%0d want count=1 cycle=2", ok_n, ok_cyc);
    end
    n_vec++;
    if (rd !== 32'h12345678) begin
      n_err++;
      $display("[TB] FAIL rd_full got %h want 12345678", rd);
    end
    n_vec++;
    if (rh !== 32'h12345678) begin
      n_err++;
      $display("[TB] FAIL rd_hold got %h want 12345678", rh);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd, rh;
    int ok_n, ok_cyc;
    logic busy_ok, back_ok;
    run_txn(0, 1'b1, 32'h11, 4'b0010, 32'hAABBCCDD, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    run_txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (rd !== 32'h1234CC78) begin
      n_err++;
      $display("[TB] FAIL byte_write got %h want 1234CC78", rd);
    end
  endtask

  task automatic test_half_and_zero_strobe();
    logic [31:0] rd, rh;
    int ok_n, ok_cyc;
    logic busy_ok, back_ok;
    run_txn(0, 1'b1, 32'h12, 4'b1100, 32'h9999EEEE, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    run_txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (rd !== 32'h9999CC78) begin
      n_err++;
      $display("[TB] FAIL half_write got %h want 9999CC78", rd);
    end
    run_txn(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (ok_n !== 1) begin
      n_err++;
      $display("[TB] FAIL zero_strobe_pulse got count=%0d want 1", ok_n);
    end
    run_txn(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (rd !== 32'h9999CC78) begin
      n_err++;
      $display("[TB] FAIL zero_strobe_data got %h want 9999CC78", rd);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd, rh;
    int ok_n, ok_cyc;
    logic busy_ok, back_ok;
    run_txn(0, 1'b1, 32'h1010, 4'b1111, 32'hDEADBEEF, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    run_txn(0, 1'b0, 32'h0010, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (rd !== 32'hDEADBEEF) begin
      n_err++;
      $display("[TB] FAIL alias got %h want DEADBEEF", rd);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] rd, rh;
    int ok_n, ok_cyc, stray;
    logic busy_ok, back_ok;
    run_txn(0, 1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wstrb[0] = 4'b1111; wdata[0] = 32'h0;
    @(posedge clk);
    #1 req[0] = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (data_ok[0] !== 1'b0 || addr_ok[0] !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL rst_during_busy got data_ok=%b addr_ok=%b want 0/1", data_ok[0], addr_ok[0]);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (addr_ok[0] !== 1'b1 || data_ok[0] !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rst_release got addr_ok=%b data_ok=%b want 1/0", addr_ok[0], data_ok[0]);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (data_ok[0] !== 1'b0) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_err++;
      $display("[TB] FAIL rst_no_pulse got %0d stray pulses want 0", stray);
    end
    run_txn(0, 1'b0, 32'h20, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
    n_vec++;
    if (rd !== 32'hCAFEF00D) begin
      n_err++;
      $display("[TB] FAIL rst_dropped_write got %h want CAFEF00D", rd);
    end
  endtask

  task automatic test_latency_variants();
    logic [31:0] rd, rh;
    int ok_n, ok_cyc;
    logic busy_ok, back_ok;
    for (int d = 1; d < 3; d++) begin
      run_txn(d, 1'b1, 32'h40, 4'b1111, 32'h0BADF00D, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
      n_vec++;
      if (ok_n !== 1 || ok_cyc !== lat_of(d) || busy_ok !== 1'b1 || back_ok !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL lat%0d_write got count=%0d cycle=%0d busy=%b back=%b want 1/%0d/1/1",
                 lat_of(d), ok_n, ok_cyc, busy_ok, back_ok, lat_of(d));
      end
      run_txn(d, 1'b0, 32'h40, 4'b0000, 32'h0, rd, ok_n, ok_cyc, busy_ok, back_ok, rh);
      n_vec++;
      if (rd !== 32'h0BADF00D || ok_cyc !== lat_of(d)) begin
        n_err++;
        $display("[TB] FAIL lat%0d_read got data=%h cycle=%0d want 0BADF00D/%0d",
                 lat_of(d), rd, ok_cyc, lat_of(d));
      end
    end
  endtask

  task automatic test_back_to_back(input int d);
    int l, acc, ok, cyc, last, interval_bad, overlap_bad, extra;
    l = lat_of(d);
    acc = 0; ok = 0; cyc = 0; last = 0; interval_bad = 0; overlap_bad = 0; extra = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = 32'h40; wstrb[d] = 4'b0000; wdata[d] = 32'h0;
    while (ok < 8 && cyc < 200) begin
      if (data_ok[d] === 1'b1) ok++;
      if (acc - ok > 1 || acc - ok < 0) overlap_bad++;
      if (addr_ok[d] === 1'b1 && data_ok[d] === 1'b1) overlap_bad++;
      if (req[d] && addr_ok[d] === 1'b1) begin
        acc++;
        if (acc > 1 && cyc - last != l + 1) interval_bad++;
        last = cyc;
      end
      @(posedge clk);
      #1 if (acc >= 8) req[d] = 1'b0;
      @(negedge clk);
      cyc++;
    end
    repeat (2 * (l + 1)) begin
      if (data_ok[d] === 1'b1) extra++;
      @(negedge clk);
    end
    req[d] = 1'b0;
    n_vec++;
    if (acc !== 8 || ok !== 8) begin
      n_err++;
      $display("[TB] FAIL b2b_lat%0d_count got acc=%0d ok=%0d want 8/8", l, acc, ok);
    end
    n_vec++;
    if (interval_bad !== 0) begin
      n_err++;
      $display("[TB] FAIL b2b_lat%0d_interval got %0d bad gaps want 0 (gap %0d)", l, interval_bad, l + 1);
    end
    n_vec++;
    if (overlap_bad !== 0 || extra !== 0) begin
      n_err++;
      $display("[TB] FAIL b2b_lat%0d_outstanding got overlap=%0d extra=%0d want 0/0", l, overlap_bad, extra);
    end
  endtask

  // Test sequence: every scenario in turn, then the summary line.
  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 3'b000;
    we    = 3'b000;
    for (int d = 0; d < 3; d++) begin
      addr[d]  = 32'd0;
      wstrb[d] = 4'd0;
      wdata[d] = 32'd0;
    end
    test_reset();
    test_full_write_read();
    test_byte_write();
    test_half_and_zero_strobe();
    test_alias();
    test_reset_mid_busy();
    test_latency_variants();
    test_back_to_back(1);
    test_back_to_back(2);
    test_back_to_back(0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
